// File: rtl/sdfm_pkg.sv
// Shared constants for the sigma-delta sinc decimation filter.
package sdfm_pkg;

  localparam int DATA_W    = 32;
  localparam int OSR_W     = 8;
  localparam int SHIFT_MAX = 24;

  localparam logic [1:0] ORDER_SINC1 = 2'd1;
  localparam logic [1:0] ORDER_SINC2 = 2'd2;
  localparam logic [1:0] ORDER_SINC3 = 2'd3;

  // Number of decimated words swallowed after enable before the comb chain holds
  // a full history (order-1; encodings 0 and 1 are both sinc1).
  function automatic logic [1:0] settle_words(input logic [1:0] order);
    case (order)
      ORDER_SINC3: settle_words = 2'd2;
      ORDER_SINC2: settle_words = 2'd1;
      default:     settle_words = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdfm_sinc_stage.sv
// One CIC stage: a modulator-rate integrator and an output-rate comb delay.
module sdfm_sinc_stage
  import sdfm_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         int_en,
  input  logic [W-1:0] int_in,
  input  logic         comb_en,
  input  logic [W-1:0] comb_in,
  output logic [W-1:0] int_q,
  output logic [W-1:0] comb_q
);

  logic [W-1:0] int_d;
  logic [W-1:0] comb_d;

  // Next-state: integrator wraps modulo 2^W, comb delay captures the stage input.
  always_comb begin
    int_d  = int_q;
    comb_d = comb_q;
    if (clr) begin
      int_d  = '0;
      comb_d = '0;
    end else begin
      if (int_en)  int_d  = int_q + int_in;
      if (comb_en) comb_d = comb_in;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q  <= '0;
      comb_q <= '0;
    end else begin
      int_q  <= int_d;
      comb_q <= comb_d;
    end
  end

endmodule

// File: rtl/sdfm_sinc_filter.sv
// Sinc1/2/3 decimation filter for one sigma-delta channel, feeding the SHIFT unit.
module sdfm_sinc_filter
  import sdfm_pkg::*;
#(
  parameter int DATA_W = sdfm_pkg::DATA_W,
  parameter int OSR_W  = sdfm_pkg::OSR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        order,
  input  logic [OSR_W-1:0]  osr,
  input  logic              sd_bit,
  input  logic              sd_strobe,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  logic              en_q,     en_d;
  logic [1:0]        order_q,  order_d;
  logic [OSR_W-1:0]  osr_q,    osr_d;
  logic [OSR_W-1:0]  cnt_q,    cnt_d;
  logic              tick_q,   tick_d;
  logic [1:0]        settle_q, settle_d;
  logic [DATA_W-1:0] out_q,    out_d;
  logic              valid_q,  valid_d;

  logic              en_rise;
  logic [OSR_W-1:0]  osr_eff;
  logic              int_en;
  logic              comb_fire;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] i1, i2, i3;
  logic [DATA_W-1:0] d1, d2, d3;
  logic [DATA_W-1:0] s, c1, c2, c3, result;

  // Config is taken from the ports on the enable-rise edge itself, so a strobe on
  // that edge already counts against the new ratio.
  assign en_rise   = enable & ~en_q;
  assign osr_eff   = en_rise ? osr : osr_q;
  assign int_en    = enable & sd_strobe;
  assign comb_fire = enable & tick_q;
  assign x         = sd_bit ? {{(DATA_W-1){1'b0}}, 1'b1} : {DATA_W{1'b1}};

  sdfm_sinc_stage #(.W(DATA_W)) u_stage1 (
    .clk(clk), .rst_n(rst_n), .clr(~enable),
    .int_en(int_en), .int_in(x), .comb_en(comb_fire), .comb_in(s),
    .int_q(i1), .comb_q(d1)
  );

  sdfm_sinc_stage #(.W(DATA_W)) u_stage2 (
    .clk(clk), .rst_n(rst_n), .clr(~enable),
    .int_en(int_en), .int_in(i1), .comb_en(comb_fire), .comb_in(c1),
    .int_q(i2), .comb_q(d2)
  );

  sdfm_sinc_stage #(.W(DATA_W)) u_stage3 (
    .clk(clk), .rst_n(rst_n), .clr(~enable),
    .int_en(int_en), .int_in(i2), .comb_en(comb_fire), .comb_in(c2),
    .int_q(i3), .comb_q(d3)
  );

  // Order mux into the comb chain and out of it; unused comb delays update harmlessly.
  always_comb begin
    s      = i1;
    result = c1;
    c1     = s - d1;
    c2     = c1 - d2;
    c3     = c2 - d3;
    case (order_q)
      ORDER_SINC3: begin
        s      = i3;
        c1     = s - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
        result = c3;
      end
      ORDER_SINC2: begin
        s      = i2;
        c1     = s - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
        result = c2;
      end
      default: begin
        s      = i1;
        c1     = s - d1;
        c2     = c1 - d2;
        c3     = c2 - d3;
        result = c1;
      end
    endcase
  end

  // Control next-state: config latch, decimation counter, settle gating, output word.
  always_comb begin
    en_d     = enable;
    order_d  = order_q;
    osr_d    = osr_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    settle_d = settle_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    if (en_rise) begin
      order_d = order;
      osr_d   = osr;
    end
    if (!enable) begin
      cnt_d    = '0;
      settle_d = '0;
    end else begin
      if (sd_strobe) begin
        if (cnt_q == osr_eff) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (tick_q) begin
        out_d = result;
        if (settle_q >= settle_words(order_q)) valid_d  = 1'b1;
        else                                   settle_d = settle_q + 2'd1;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      order_q  <= ORDER_SINC1;
      osr_q    <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      settle_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      en_q     <= en_d;
      order_q  <= order_d;
      osr_q    <= osr_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      settle_q <= settle_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign data_out   = out_q;
  assign data_valid = valid_q;

endmodule
